// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams words into imem, holds the core in reset, then releases it.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic [31:0]           PCIn,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_RUN, S_ERROR
    } state_t;

    localparam int RW = $clog2(RELEASE_CYCLES + 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [RW-1:0]         rel_cnt_q, rel_cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic [31:0]           pc_q, pc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  handshake;
    logic                  start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic                  error_q, error_d;
    logic [31:0]           xor_q, xor_d;
`endif

    assign handshake = in_valid & in_ready_q;
    assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_ERROR));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        idx_d        = idx_q;
        rel_cnt_d    = rel_cnt_q;
        in_ready_d   = in_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        pc_d         = pc_q;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        error_d      = error_q;
        xor_d        = xor_q;
`endif
        if (start_ok) begin
            base_d      = base_addr;
            count_d     = load_count;
            idx_d       = '0;
            rel_cnt_d   = '0;
            pc_d        = 32'({base_addr, 2'b00});
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            busy_d      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_d     = 1'b0;
            xor_d       = '0;
`endif
            if (load_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d    = S_CHECK;
                in_ready_d = 1'b1;
`else
                state_d    = S_RELEASE;
                in_ready_d = 1'b0;
`endif
            end else begin
                state_d    = S_LOAD;
                in_ready_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (handshake) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = base_q + idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = in_data;
                        idx_d        = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d        = xor_q ^ in_data;
                        if (idx_d == count_q) begin
                            state_d = S_CHECK;
                        end
`else
                        if (idx_d == count_q) begin
                            state_d    = S_RELEASE;
                            in_ready_d = 1'b0;
                            rel_cnt_d  = '0;
                        end
`endif
                    end
                end
                S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // The checksum word is consumed here and never written to memory.
                    if (handshake) begin
                        in_ready_d = 1'b0;
                        if (in_data == xor_q) begin
                            state_d   = S_RELEASE;
                            rel_cnt_d = '0;
                        end else begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
`endif
                end
                S_RELEASE: begin
                    if (rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
                        state_d     = S_RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        rel_cnt_d = rel_cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            rel_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            pc_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_q      <= 1'b0;
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            rel_cnt_q    <= rel_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            pc_q         <= pc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_q      <= error_d;
            xor_q        <= xor_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign PCIn       = pc_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; also covers the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  load_count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic [31:0] PCIn;
    logic        busy;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;

    imem_loader #(.ADDR_WIDTH(8), .RELEASE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .load_count(load_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .PCIn(PCIn),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_count = wr_count + 1;
            $display("write addr=%02h data=%08h", imem_addr, imem_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (PCIn !== 32'h0) begin miscompares++; $display("FAIL reset_pcin got=%h exp=0", PCIn); end
        vectors++; if (busy !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, error); end
    endtask

    task automatic test_basic_load();
        logic [31:0] w[3];
        w[0] = 32'h00221820; w[1] = 32'h00421822; w[2] = 32'h00632024;
        base_addr = 8'h00; load_count = 9'd3; start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL basic_start rdy/busy/crst got=%b%b%b exp=111", in_ready, busy, cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = w[i];
            step();
            vectors++;
            if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== w[i]) begin
                miscompares++; $display("FAIL basic_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, imem_we, imem_addr, imem_wdata, i, w[i]);
            end
        end
        in_valid = 1'b0; in_data = 32'hDEADBEEF;
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_valid = 1'b1; in_data = 32'h00032026;
        step();
        in_valid = 1'b0;
`endif
        vectors++; if (in_ready !== 1'b0 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL basic_release_entry rdy/crst got=%b%b exp=01", in_ready, cpu_reset); end
        step();
        vectors++; if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_release1 crst/we/done got=%b%b%b exp=100", cpu_reset, imem_we, done); end
        step();
        vectors++; if (cpu_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_run crst/done/busy got=%b%b%b exp=010", cpu_reset, done, busy); end
        vectors++; if (PCIn !== 32'h0 || error !== 1'b0) begin miscompares++; $display("FAIL basic_pcin_err got pc=%h err=%b exp pc=0 err=0", PCIn, error); end
    endtask

    task automatic test_stall_wrap();
        logic [7:0] exp_a[4];
        int k;
        int snap;
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        snap = wr_count;
        base_addr = 8'hFE; load_count = 9'd4; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            in_valid = (c % 2 == 0);
            in_data = 32'hA0 + 32'(k);
            if (in_valid) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready%0d got=%b exp=1", k, in_ready); end
            end
            step();
            if (in_valid) begin
                vectors++;
                if (imem_we !== 1'b1 || imem_addr !== exp_a[k] || imem_wdata !== 32'hA0 + 32'(k)) begin
                    miscompares++; $display("FAIL stall_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", k, imem_we, imem_addr, imem_wdata, exp_a[k], 32'hA0 + 32'(k));
                end
                k++;
            end else begin
                vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL stall_idle_we got=%b exp=0", imem_we); end
            end
        end
        in_valid = 1'b0;
        vectors++; if (k !== 4) begin miscompares++; $display("FAIL stall_budget got=%0d words exp=4", k); end
        vectors++; if (PCIn !== 32'h3F8) begin miscompares++; $display("FAIL stall_pcin got=%h exp=3f8", PCIn); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_valid = 1'b1; in_data = 32'h0;
        step();
        in_valid = 1'b0;
`endif
        step();
        step();
        vectors++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin miscompares++; $display("FAIL stall_done done/crst got=%b%b exp=10", done, cpu_reset); end
        vectors++; if (wr_count - snap !== 4) begin miscompares++; $display("FAIL stall_write_count got=%0d exp=4", wr_count - snap); end
    endtask

    task automatic test_zero_restart();
        int snap;
        snap = wr_count;
        base_addr = 8'h05; load_count = 9'd0; start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL zero_restart crst/done/busy got=%b%b%b exp=101", cpu_reset, done, busy); end
        vectors++; if (PCIn !== 32'h14) begin miscompares++; $display("FAIL zero_pcin got=%h exp=14", PCIn); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_valid = 1'b1; in_data = 32'h0;
        step();
        in_valid = 1'b0;
`endif
        step();
        vectors++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL zero_release crst/done got=%b%b exp=10", cpu_reset, done); end
        step();
        vectors++; if (cpu_reset !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL zero_done crst/done got=%b%b exp=01", cpu_reset, done); end
        vectors++; if (wr_count !== snap) begin miscompares++; $display("FAIL zero_no_writes got=%0d exp=0", wr_count - snap); end
    endtask

    task automatic test_start_in_load();
        base_addr = 8'h10; load_count = 9'd2; start = 1'b1;
        step();
        base_addr = 8'h20; load_count = 9'd1; start = 1'b1;
        in_valid = 1'b1; in_data = 32'h11111111;
        step();
        start = 1'b0;
        vectors++; if (imem_addr !== 8'h10 || PCIn !== 32'h40) begin miscompares++; $display("FAIL ign_start_w0 got a=%h pc=%h exp a=10 pc=40", imem_addr, PCIn); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ign_start_count got rdy=%b exp=1", in_ready); end
        in_data = 32'h22222222;
        step();
        vectors++; if (imem_we !== 1'b1 || imem_addr !== 8'h11) begin miscompares++; $display("FAIL ign_start_w1 got we=%b a=%h exp we=1 a=11", imem_we, imem_addr); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_data = 32'h33333333;
        step();
`endif
        in_valid = 1'b0;
        step();
        step();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ign_start_done got=%b exp=1", done); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int snap;
        for (int pass = 0; pass < 2; pass++) begin
            snap = wr_count;
            base_addr = 8'h30; load_count = 9'd2; start = 1'b1;
            step();
            start = 1'b0;
            vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL csum%0d_err_clear got=%b exp=0", pass, error); end
            in_valid = 1'b1; in_data = 32'h1; step();
            in_data = 32'h2; step();
            in_data = (pass == 0) ? 32'h3 : 32'h7; step();
            in_valid = 1'b0;
            vectors++; if (imem_we !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL csum%0d_consumed we/rdy got=%b%b exp=00", pass, imem_we, in_ready); end
            if (pass == 0) begin
                step(); step();
                vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("FAIL csum_ok done/err got=%b%b exp=10", done, error); end
            end else begin
                vectors++; if (error !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL csum_bad err/crst/busy got=%b%b%b exp=110", error, cpu_reset, busy); end
                step(); step(); step();
                vectors++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL csum_hold err/crst/done got=%b%b%b exp=110", error, cpu_reset, done); end
            end
            vectors++; if (wr_count - snap !== 2) begin miscompares++; $display("FAIL csum%0d_writes got=%0d exp=2", pass, wr_count - snap); end
        end
    endtask
`endif

    task automatic test_reset_mid_load();
        int snap;
        snap = wr_count;
        base_addr = 8'h00; load_count = 9'd5; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'hC0; step();
        in_data = 32'hC1; step();
        vectors++; if (imem_addr !== 8'h01 || imem_we !== 1'b1) begin miscompares++; $display("FAIL rml_w1 got we=%b a=%h exp we=1 a=01", imem_we, imem_addr); end
        reset = 1'b1; start = 1'b1; in_data = 32'hC2;
        step();
        reset = 1'b0; start = 1'b0;
        vectors++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rml_reset we/rdy/busy got=%b%b%b exp=000", imem_we, in_ready, busy); end
        vectors++; if (cpu_reset !== 1'b1 || done !== 1'b0 || PCIn !== 32'h0 || imem_addr !== 8'h0) begin miscompares++; $display("FAIL rml_reset crst=%b done=%b pc=%h a=%h exp 1 0 0 0", cpu_reset, done, PCIn, imem_addr); end
        step(); step(); step();
        in_valid = 1'b0;
        vectors++; if (wr_count - snap !== 2) begin miscompares++; $display("FAIL rml_writes got=%0d exp=2", wr_count - snap); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_load();
        test_stall_wrap();
        test_zero_restart();
        test_start_in_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle datapath. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory. While loading, it holds the core in reset. It then supplies the start PC on `PCIn` and releases the core. This block is the writer side of the instruction fetch path the datapath reads from, and it replaces bench-driven `reset`/`PCIn` sequencing.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction memory word-address width (depth 2^ADDR_WIDTH).
- `RELEASE_CYCLES`, 2: cycles `cpu_reset` stays high after the final write cycle; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle load request.
- `base_addr`  in  ADDR_WIDTH  first word address; latched on accepted `start`.
- `load_count`  in  ADDR_WIDTH+1  number of program words; latched on accepted `start`.
- `in_valid`  in  1  source has a word.
- `in_data`  in  32  instruction word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_WIDTH  write word address.
- `imem_wdata`  out  32  write data.
- `cpu_reset`  out  1  reset to the datapath; active-high.
- `PCIn`  out  32  start PC to the datapath, equal to `{base_addr, 2'b00}` zero-extended.
- `busy`  out  1  load in progress.
- `done`  out  1  program loaded and core released.
- `error`  out  1  checksum failure.

## Operation
- States: IDLE, LOAD, CHECK, RELEASE, RUN, ERROR.
- **Reset values:** state IDLE, `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `PCIn`=0, `busy`=0, `done`=0, `error`=0, and all counters 0.
- `start` is accepted in IDLE, RUN or ERROR and ignored in LOAD, CHECK and RELEASE. On acceptance:
  - `base_addr`/`load_count` are latched; `PCIn` updates.
  - `cpu_reset`=1, `done`=0, `error`=0, `busy`=1.
  - Next state is LOAD; with `load_count`=0 it goes straight to RELEASE, or to CHECK when checksum is enabled.
- **LOAD:** `in_ready`=1. A handshake (`in_valid & in_ready`) writes the word at `base_addr + index`. The index increments per handshake.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top is silent.
  - After handshake number `load_count`, go to CHECK when checksum is enabled, otherwise RELEASE.
- **CHECK:** see Configuration.
- **RELEASE:** `in_ready`=0, `cpu_reset`=1. A counter runs RELEASE_CYCLES cycles, then the state moves to RUN.
- **RUN:** `cpu_reset`=0, `done`=1, `busy`=0, `in_ready`=0. `PCIn` holds its value.
- **ERROR:** `error`=1, `cpu_reset`=1, `busy`=0, `in_ready`=0. It is left only by `start` or `reset`.
- Asserting `reset` mid-load returns the block to reset values next edge. Words already written stay in memory.

## Timing
- `in_ready` rises the cycle after `start` is accepted.
- **Write latency is 1:** `imem_we`/`imem_addr`/`imem_wdata` are registered and asserted the cycle after each handshake, for exactly one cycle per word. Back-to-back handshakes give back-to-back writes.
- The first RELEASE cycle coincides with the final `imem_we` pulse. `cpu_reset` falls and `done` rises RELEASE_CYCLES cycles after entering RELEASE.
- `in_valid` low stalls LOAD indefinitely with no timeout. `in_data` is ignored when there is no handshake.
- `start` and `reset` in the same cycle: `reset` wins.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - A running XOR of all accepted program words is kept.
  - In CHECK, `in_ready`=1 and one extra word (the checksum) is accepted. It is not written to memory.
  - Match goes to RELEASE; mismatch goes to ERROR the next cycle.
- **Undefined:** CHECK and ERROR are unreachable, `error` is tied 0, and no extra word is consumed.

## Test plan
- **Reset:** `reset`=1 for 2 cycles. Check `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `done`=0, `PCIn`=0.
- **Basic load:** `base_addr`=0, `load_count`=3, words 0x00221820, 0x00421822, 0x00632024 sent back-to-back.
  - Writes to addresses 0,1,2, one cycle after each handshake.
  - `cpu_reset` falls 2 cycles after the last handshake+1; `done`=1; `PCIn`=0.
- **Stall and wrap:** `ADDR_WIDTH`=8, `base_addr`=0xFE, `load_count`=4, `in_valid` toggled every other cycle.
  - Writes land at 0xFE, 0xFF, 0x00, 0x01 with no duplicates.
  - `PCIn`=0x3F8.
- **Zero count and restart:** `load_count`=0 gives no writes and `done` after RELEASE_CYCLES.
  - A `start` while in RUN re-raises `cpu_reset` next cycle.
  - A `start` in LOAD is ignored.
- **Checksum (macro defined):**
  - Words 0x1, 0x2 with checksum 0x3 leads to `done`=1.
  - Checksum 0x7 leads to `error`=1 with `cpu_reset` held at 1, and a new `start` clears `error`.
- **Reset mid-load:** `reset` asserted after 2 of 5 words.
  - State returns to IDLE with reset values next edge.
  - Addresses 0–1 are written; no further `imem_we`.
